// File: rtl/trng_sampler.sv
// trng_sampler: consumer side of the ring-oscillator entropy source.
// Owns the ring halt control, synchronises and XOR-combines the raw ring
// outputs, decimates them, applies von Neumann debiasing and packs the
// surviving bits into words offered on a valid/ready interface.
//
// Optional build macro: TRNG_HEALTH_TEST_EN adds a repetition-count health
// test on the decimated raw stream; without it health_fail is tied low.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | rings halted, waiting for en
// WARMUP  | rings running, settling for WARMUP_CYCLES clocks
// COLLECT | sampling every SAMPLE_DIV clocks, debiasing, packing bits
// HOLD    | full word offered; rings keep running, no sampling
module trng_sampler #(
    parameter int NUM_RO        = 4,
    parameter int WORD_WIDTH    = 32,
    parameter int SAMPLE_DIV    = 16,
    parameter int WARMUP_CYCLES = 256,
    parameter int REP_LIMIT     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_RO-1:0]     ro_bits,
    output logic                  ro_halt,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  busy,
    output logic                  health_fail
);

    localparam int SDIV_W = $clog2(SAMPLE_DIV);
    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int BIT_W  = $clog2(WORD_WIDTH);
    localparam int RUN_W  = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WARMUP  = 2'd1,
        S_COLLECT = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [NUM_RO-1:0]     r_sync1;
    logic [NUM_RO-1:0]     r_sync2;
    logic [WARM_W-1:0]     r_warm_cnt;
    logic [SDIV_W-1:0]     r_samp_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic                  r_pend_vld;
    logic                  r_pend_bit;
    logic [WORD_WIDTH-1:0] r_word;
    logic                  r_word_valid;
    logic                  r_ro_halt;
    logic                  r_busy;
    logic                  r_health_fail;

    logic w_raw;
    logic w_strobe;
    logic w_emit;
    logic w_word_done;
    logic w_handshake;
    logic w_health_trip;
    logic w_ro_halt_next;
    logic w_busy_next;

    assign w_raw       = ^r_sync2;
    assign w_strobe    = (r_state == S_COLLECT) && (r_samp_cnt == SDIV_W'(SAMPLE_DIV - 1));
    assign w_emit      = w_strobe && r_pend_vld && (r_pend_bit != w_raw);
    assign w_word_done = w_emit && (r_bit_cnt == BIT_W'(WORD_WIDTH - 1));
    assign w_handshake = r_word_valid && word_ready;

`ifdef TRNG_HEALTH_TEST_EN
    logic [RUN_W-1:0] r_run_cnt;
    logic             r_last_raw;
    logic [RUN_W-1:0] w_run_next;

    // Length of the current run of identical decimated samples, counting this strobe
    always_comb begin
        w_run_next = RUN_W'(1);
        if ((r_run_cnt != '0) && (w_raw == r_last_raw)) begin
            w_run_next = r_run_cnt + RUN_W'(1);
        end
    end

    assign w_health_trip = w_strobe && (w_run_next == RUN_W'(REP_LIMIT));

    // Run tracker persists across HOLD so a stuck source cannot hide behind word boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cnt  <= '0;
            r_last_raw <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_run_cnt  <= '0;
        end else if (w_strobe) begin
            r_run_cnt  <= w_run_next;
            r_last_raw <= w_raw;
        end
    end
`else
    assign w_health_trip = 1'b0;
`endif

    // State register plus registered FSM-decoded outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ro_halt <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ro_halt <= w_ro_halt_next;
            r_busy    <= w_busy_next;
        end
    end

    // Next-state decode; a tripped health test wins over everything else in COLLECT
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (en && !r_health_fail) w_state_next = S_WARMUP;
            end
            S_WARMUP: begin
                if (!en)                    w_state_next = S_IDLE;
                else if (r_warm_cnt == '0)  w_state_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (!en || w_health_trip)   w_state_next = S_IDLE;
                else if (w_word_done)       w_state_next = S_HOLD;
            end
            S_HOLD: begin
                if (w_handshake)            w_state_next = en ? S_COLLECT : S_IDLE;
            end
            default:                        w_state_next = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state
    always_comb begin
        w_ro_halt_next = (w_state_next == S_IDLE);
        w_busy_next    = (w_state_next != S_IDLE);
    end

    // Synchronisers, warm-up timer, decimation, debiasing and word packing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_warm_cnt    <= '0;
            r_samp_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_pend_vld    <= 1'b0;
            r_pend_bit    <= 1'b0;
            r_word        <= '0;
            r_word_valid  <= 1'b0;
            r_health_fail <= 1'b0;
        end else begin
            r_sync1 <= ro_bits;
            r_sync2 <= r_sync1;

            if (r_state != S_WARMUP) begin
                r_warm_cnt <= WARM_W'(WARMUP_CYCLES - 1);
            end else if (r_warm_cnt != '0) begin
                r_warm_cnt <= r_warm_cnt - WARM_W'(1);
            end

            if (r_state != S_COLLECT) begin
                r_samp_cnt <= '0;
                r_bit_cnt  <= '0;
                r_pend_vld <= 1'b0;
            end else begin
                r_samp_cnt <= w_strobe ? '0 : r_samp_cnt + SDIV_W'(1);
                if (w_strobe) begin
                    if (r_pend_vld) begin
                        r_pend_vld <= 1'b0;
                        if (w_emit) r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end else begin
                        r_pend_vld <= 1'b1;
                        r_pend_bit <= w_raw;
                    end
                end
            end

            if ((r_state == S_COLLECT) && (w_state_next == S_IDLE)) begin
                r_word <= '0;
            end else if (w_emit) begin
                r_word <= {r_word[WORD_WIDTH-2:0], r_pend_bit};
            end

            if ((r_state == S_COLLECT) && (w_state_next == S_HOLD)) begin
                r_word_valid <= 1'b1;
            end else if (w_handshake) begin
                r_word_valid <= 1'b0;
            end

            if (w_health_trip) r_health_fail <= 1'b1;
        end
    end

    assign ro_halt     = r_ro_halt;
    assign word        = r_word;
    assign word_valid  = r_word_valid;
    assign busy        = r_busy;
    assign health_fail = r_health_fail;

endmodule

// File: tb/tb_trng_sampler.sv
// Directed bench for trng_sampler: NUM_RO=1, WORD_WIDTH=8, SAMPLE_DIV=4,
// WARMUP_CYCLES=8, REP_LIMIT=6. Inputs change 1 ns after the rising edge
// and outputs are sampled at the same point.
module tb_trng_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [0:0] ro_bits = 1'b0;
    logic       ro_halt;
    logic [7:0] word;
    logic       word_valid;
    logic       word_ready = 1'b0;
    logic       busy;
    logic       health_fail;

    int n_cmp  = 0;
    int n_fail = 0;

    trng_sampler #(
        .NUM_RO(1), .WORD_WIDTH(8), .SAMPLE_DIV(4), .WARMUP_CYCLES(8), .REP_LIMIT(6)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ro_bits(ro_bits), .ro_halt(ro_halt),
        .word(word), .word_valid(word_valid), .word_ready(word_ready),
        .busy(busy), .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    // Plays one word's worth of raw pairs starting at COLLECT cycle 0.
    // Bit i (MSB first) is sent as (b, ~b); each sample is held for one
    // decimation period. Records how often ro_halt and word_valid were high.
    task automatic play_pairs(input logic [7:0] bits, output int halt_hi, output int valid_seen);
        halt_hi    = 0;
        valid_seen = 0;
        for (int i = 7; i >= 0; i--) begin
            for (int h = 0; h < 2; h++) begin
                ro_bits = (h == 0) ? bits[i] : ~bits[i];
                repeat (4) begin
                    @(posedge clk); #1;
                    if (ro_halt)    halt_hi++;
                    if (word_valid) valid_seen++;
                end
            end
        end
    endtask

    task automatic test_reset;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ro_halt, word_valid, word, busy, health_fail} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_values cycle %0d: got halt=%b vld=%b word=%h busy=%b hf=%b, want 1 0 00 0 0",
                         c, ro_halt, word_valid, word, busy, health_fail);
            end
        end
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_after_release: busy=%b want 0", busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, ro_halt} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_enter_warmup: busy=%b halt=%b want 1 0", busy, ro_halt);
        end
    endtask

    task automatic test_balanced;
        int bad = 0;
        int halt_hi, valid_seen;
        repeat (8) begin
            @(posedge clk); #1;
            if (!busy || ro_halt || word_valid) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL balanced_warmup: %0d bad cycles, want 0", bad);
        end
        play_pairs(8'hFF, halt_hi, valid_seen);
        n_cmp++;
        if (halt_hi !== 0) begin
            n_fail++;
            $display("FAIL balanced_halt: ro_halt high %0d cycles, want 0", halt_hi);
        end
        n_cmp++;
        if (valid_seen !== 1) begin
            n_fail++;
            $display("FAIL balanced_valid_timing: valid seen %0d cycles, want 1", valid_seen);
        end
        n_cmp++;
        if ({word_valid, word} !== {1'b1, 8'hFF}) begin
            n_fail++;
            $display("FAIL balanced_word: vld=%b word=%h want 1 ff", word_valid, word);
        end
    endtask

    task automatic test_backpressure;
        int bad = 0;
        int halt_hi, valid_seen;
        repeat (20) begin
            @(posedge clk); #1;
            if (word !== 8'hFF || word_valid !== 1'b1 || busy !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d unstable cycles, want 0", bad);
        end
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        n_cmp++;
        if ({word_valid, busy, ro_halt} !== 3'b010) begin
            n_fail++;
            $display("FAIL backpressure_accept: vld=%b busy=%b halt=%b want 0 1 0", word_valid, busy, ro_halt);
        end
        play_pairs(8'hB2, halt_hi, valid_seen);
        n_cmp++;
        if (valid_seen !== 1 || halt_hi !== 0) begin
            n_fail++;
            $display("FAIL backpressure_next_timing: valid %0d cycles halt %0d cycles, want 1 0", valid_seen, halt_hi);
        end
        n_cmp++;
        if ({word_valid, word} !== {1'b1, 8'hB2}) begin
            n_fail++;
            $display("FAIL backpressure_next_word: vld=%b word=%h want 1 b2", word_valid, word);
        end
    endtask

    task automatic test_biased;
        int vld_cnt = 0;
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        for (int k = 0; k < 50; k++) begin
            ro_bits = ((k % 4) < 2) ? 1'b1 : 1'b0;
            repeat (4) begin
                @(posedge clk); #1;
                if (word_valid) vld_cnt++;
            end
        end
        n_cmp++;
        if (vld_cnt !== 0) begin
            n_fail++;
            $display("FAIL biased_no_valid: valid high %0d cycles, want 0", vld_cnt);
        end
        n_cmp++;
        if ({busy, word} !== {1'b1, 8'hB2}) begin
            n_fail++;
            $display("FAIL biased_no_shift: busy=%b word=%h want 1 b2", busy, word);
        end
    endtask

    task automatic test_abort;
        logic [5:0] seq;
        int halt_hi, valid_seen;
        seq = 6'b100110;
        for (int k = 5; k >= 0; k--) begin
            ro_bits = seq[k];
            repeat (4) @(posedge clk);
            #1;
        end
        n_cmp++;
        if (word !== 8'h95) begin
            n_fail++;
            $display("FAIL abort_partial_word: word=%h want 95", word);
        end
        en = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({ro_halt, busy, word_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL abort_idle: halt=%b busy=%b vld=%b want 1 0 0", ro_halt, busy, word_valid);
        end
        en = 1'b1;
        @(posedge clk); #1;
        repeat (8) @(posedge clk);
        #1;
        play_pairs(8'h69, halt_hi, valid_seen);
        n_cmp++;
        if (valid_seen !== 1 || halt_hi !== 0) begin
            n_fail++;
            $display("FAIL abort_rewarm_timing: valid %0d cycles halt %0d cycles, want 1 0", valid_seen, halt_hi);
        end
        n_cmp++;
        if ({word_valid, word} !== {1'b1, 8'h69}) begin
            n_fail++;
            $display("FAIL abort_fresh_word: vld=%b word=%h want 1 69", word_valid, word);
        end
    endtask

`ifdef TRNG_HEALTH_TEST_EN
    task automatic test_health;
        int bad = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({word_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL health_rst_drops_word: vld=%b busy=%b want 0 0", word_valid, busy);
        end
        @(posedge clk); #1;
        rst     = 1'b0;
        ro_bits = 1'b1;
        repeat (9) @(posedge clk);
        repeat (23) @(posedge clk);
        #1;
        n_cmp++;
        if ({health_fail, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL health_before_limit: hf=%b busy=%b want 0 1", health_fail, busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({health_fail, busy, ro_halt} !== 3'b101) begin
            n_fail++;
            $display("FAIL health_trip: hf=%b busy=%b halt=%b want 1 0 1", health_fail, busy, ro_halt);
        end
        repeat (50) begin
            @(posedge clk); #1;
            if (busy || !ro_halt || !health_fail) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL health_sticky_idle: %0d bad cycles, want 0", bad);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (health_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL health_rst_clear: hf=%b want 0", health_fail);
        end
    endtask
`else
    task automatic test_health_off;
        int bad = 0;
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        ro_bits    = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (health_fail || word_valid || !busy) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL health_off_stuck_source: %0d bad cycles, want 0", bad);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_balanced();
        test_backpressure();
        test_biased();
        test_abort();
`ifdef TRNG_HEALTH_TEST_EN
        test_health();
`else
        test_health_off();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
